// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control unit.
// Moore FSM sequencing, NZCV flags, condition checks, datapath selects.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   Instr[11:0]      instruction bits [31:20] {cond, op, funct}
//   ALUFlags[3:0]    {N,Z,C,V} from the datapath ALU
//   PCWrite, MemWrite, RegWrite, IRWrite   enables / strobe
//   AdrSrc           memory address select (0=PC, 1=Result)
//   RegSrc[1:0]      [0] RA1=R15, [1] RA2=Rd
//   ALUSrcA[1:0]     00=A, 01=PC
//   ALUSrcB[1:0]     00=B, 01=ExtImm, 10=4
//   ResultSrc[1:0]   00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc[1:0]      immediate format, equal to op
//   ALUControl[2:0]  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    state_t state, state_n;

    logic [3:0] cond;
    logic [1:0] op;
    logic       ibit;
    logic [3:0] cmd;
    logic       sbit;
    logic       ubit;
    logic       lbit;

    // Field positions relative to the full 32-bit instruction:
    // cond=31:28, op=27:26, I=25, cmd=24:21, U=23, S/L=20.
    assign cond = Instr[11:8];
    assign op   = Instr[7:6];
    assign ibit = Instr[5];
    assign cmd  = Instr[4:1];
    assign ubit = Instr[3];
    assign sbit = Instr[0];
    assign lbit = Instr[0];

    assign ImmSrc    = op;
    assign RegSrc[0] = (op == 2'b10);
    assign RegSrc[1] = (op == 2'b01);

    logic [2:0] alu_dec;
    logic       nowrite;
    logic       cmd_known;
    logic       cmd_arith;

    always_comb begin
        alu_dec   = ALU_ADD;
        nowrite   = 1'b0;
        cmd_known = 1'b1;
        cmd_arith = 1'b0;
        case (cmd)
            4'b0100: begin
                alu_dec   = ALU_ADD;
                cmd_arith = 1'b1;
            end
            4'b0010: begin
                alu_dec   = ALU_SUB;
                cmd_arith = 1'b1;
            end
            4'b0000: alu_dec = ALU_AND;
            4'b1100: alu_dec = ALU_ORR;
            4'b0001: alu_dec = ALU_EOR;
            4'b1010: begin
                alu_dec   = ALU_SUB;
                nowrite   = 1'b1;
                cmd_arith = 1'b1;
            end
            default: begin
                // Unsupported op: harmless ADD, no register or flag write.
                alu_dec   = ALU_ADD;
                nowrite   = 1'b1;
                cmd_known = 1'b0;
            end
        endcase
    end

    logic [3:0] flags;
    logic       fn, fz, fc, fv;
    logic       condex;
    logic       condexr;

    assign {fn, fz, fc, fv} = flags;

    always_comb begin
        condex = 1'b1;
        case (cond)
            4'b0000: condex = fz;
            4'b0001: condex = ~fz;
            4'b0010: condex = fc;
            4'b0011: condex = ~fc;
            4'b0100: condex = fn;
            4'b0101: condex = ~fn;
            4'b0110: condex = fv;
            4'b0111: condex = ~fv;
            4'b1000: condex = fc & ~fz;
            4'b1001: condex = ~fc | fz;
            4'b1010: condex = (fn == fv);
            4'b1011: condex = (fn != fv);
            4'b1100: condex = ~fz & (fn == fv);
            4'b1101: condex = fz | (fn != fv);
            default: condex = 1'b1;
        endcase
    end

    logic in_exec;
    logic nz_wr;
    logic cv_wr;

    assign in_exec = (state == S_EXECUTER) || (state == S_EXECUTEI);
    assign nz_wr   = in_exec & condex & sbit & cmd_known;
    assign cv_wr   = in_exec & condex & sbit & cmd_arith;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (nz_wr) flags[3:2] <= ALUFlags[3:2];
            if (cv_wr) flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Registered condition: writeback gating sees the flags as they
    // were before this instruction's own execute-cycle update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) condexr <= 1'b0;
        else       condexr <= condex;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_n = ibit ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_n = S_MEMADR;
                    2'b10:   state_n = S_BRANCH;
                    default: state_n = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = ubit ? ALU_ADD : ALU_SUB;
                state_n    = lbit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condexr;
                state_n   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = condexr;
                state_n  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = condexr & ~nowrite;
                state_n  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condexr;
                state_n   = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven per-cycle check of mc_controller.
// Scoreboard queue holds expected outputs, compared at the falling edge.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    mc_controller dut (
        .clk(clk),
        .reset(reset),
        .Instr(Instr),
        .ALUFlags(ALUFlags),
        .PCWrite(PCWrite),
        .MemWrite(MemWrite),
        .RegWrite(RegWrite),
        .IRWrite(IRWrite),
        .AdrSrc(AdrSrc),
        .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] instr;
        logic [3:0]  fl;
        logic [13:0] exp;
        string       tag;
    } vec_t;

    typedef struct {
        logic [17:0] exp;
        string       tag;
    } sb_t;

    vec_t tbl[$];
    vec_t tbl2[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
    localparam logic [13:0] OF = {5'b10010, 2'b01, 2'b10, 2'b10, 3'b000};
    localparam logic [13:0] OD = {5'b00000, 2'b01, 2'b10, 2'b10, 3'b000};

    function automatic logic [13:0] o(input logic pc, input logic mw,
                                      input logic rw, input logic adr,
                                      input logic [1:0] b, input logic [1:0] r,
                                      input logic [2:0] alu);
        return {pc, mw, rw, 1'b0, adr, 2'b00, b, r, alu};
    endfunction

    function automatic logic [3:0] rsi(input logic [11:0] ins);
        logic [1:0] op;
        op = ins[7:6];
        return {op == 2'b01, op == 2'b10, op};
    endfunction

    function automatic logic [17:0] act();
        return {RegSrc, ImmSrc, PCWrite, MemWrite, RegWrite, IRWrite,
                AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
    endfunction

    task automatic chk(input string tag, input logic [17:0] got,
                       input logic [17:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    task automatic v(inout vec_t q[$], input logic [11:0] ins,
                     input logic [3:0] fl, input logic [13:0] e,
                     input string tag);
        vec_t r;
        r.instr = ins;
        r.fl    = fl;
        r.exp   = e;
        r.tag   = tag;
        q.push_back(r);
    endtask

    task automatic fd(inout vec_t q[$], input logic [11:0] ins,
                      input string tag);
        v(q, ins, 4'hF, OF, {tag, "_fetch"});
        v(q, ins, 4'hF, OD, {tag, "_decode"});
    endtask

    task automatic run(input vec_t q[$]);
        sb_t s;
        foreach (q[i]) begin
            Instr    = q[i].instr;
            ALUFlags = q[i].fl;
            s.exp = {rsi(q[i].instr), q[i].exp};
            s.tag = q[i].tag;
            sb.push_back(s);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag, act(), e.exp);
        end
    end

    initial begin
        // ADD R1,R2,R3
        fd(tbl, 12'hE08, "add");
        v(tbl, 12'hE08, 4'hF, o(0,0,0,0,2'b00,2'b00,3'b000), "add_exr");
        v(tbl, 12'hE08, 4'hF, o(0,0,1,0,2'b00,2'b00,3'b000), "add_wb");
        // SUBS imm, Z set
        fd(tbl, 12'hE25, "subs");
        v(tbl, 12'hE25, 4'h4, o(0,0,0,0,2'b01,2'b00,3'b001), "subs_exi");
        v(tbl, 12'hE25, 4'hF, o(0,0,1,0,2'b00,2'b00,3'b000), "subs_wb");
        // BEQ taken, BNE not taken
        fd(tbl, 12'h0A0, "beq1");
        v(tbl, 12'h0A0, 4'hF, o(1,0,0,0,2'b01,2'b10,3'b000), "beq1_br");
        fd(tbl, 12'h1AF, "bne1");
        v(tbl, 12'h1AF, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "bne1_br");
        // LDR R4,[R5,#-8]
        fd(tbl, 12'hE51, "ldr");
        v(tbl, 12'hE51, 4'hF, o(0,0,0,0,2'b01,2'b00,3'b001), "ldr_ma");
        v(tbl, 12'hE51, 4'hF, o(0,0,0,1,2'b00,2'b00,3'b000), "ldr_mr");
        v(tbl, 12'hE51, 4'hF, o(0,0,1,0,2'b00,2'b01,3'b000), "ldr_wb");
        // CMP sets flags to 1000
        fd(tbl, 12'hE15, "cmp");
        v(tbl, 12'hE15, 4'h8, o(0,0,0,0,2'b00,2'b00,3'b001), "cmp_exr");
        v(tbl, 12'hE15, 4'hF, o(0,0,0,0,2'b00,2'b00,3'b000), "cmp_wb");
        // ORR without S must leave flags
        fd(tbl, 12'hE18, "orr");
        v(tbl, 12'hE18, 4'h6, o(0,0,0,0,2'b00,2'b00,3'b011), "orr_exr");
        v(tbl, 12'hE18, 4'hF, o(0,0,1,0,2'b00,2'b00,3'b000), "orr_wb");
        // Flags 1000: EQ no, MI yes, CS no, LT yes
        fd(tbl, 12'h0A0, "beq2");
        v(tbl, 12'h0A0, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "beq2_br");
        fd(tbl, 12'h4A0, "bmi");
        v(tbl, 12'h4A0, 4'hF, o(1,0,0,0,2'b01,2'b10,3'b000), "bmi_br");
        fd(tbl, 12'h2A0, "bcs");
        v(tbl, 12'h2A0, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "bcs_br");
        fd(tbl, 12'hBA0, "blt");
        v(tbl, 12'hBA0, 4'hF, o(1,0,0,0,2'b01,2'b10,3'b000), "blt_br");
        // ADDSEQ skipped: no write, no flag update
        fd(tbl, 12'h009, "addseq");
        v(tbl, 12'h009, 4'h4, o(0,0,0,0,2'b00,2'b00,3'b000), "addseq_exr");
        v(tbl, 12'h009, 4'hF, o(0,0,0,0,2'b00,2'b00,3'b000), "addseq_wb");
        fd(tbl, 12'h0A0, "beq3");
        v(tbl, 12'h0A0, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "beq3_br");
        // STREQ with Z=0, then STR always
        fd(tbl, 12'h058, "streq");
        v(tbl, 12'h058, 4'hF, o(0,0,0,0,2'b01,2'b00,3'b000), "streq_ma");
        v(tbl, 12'h058, 4'hF, o(0,0,0,1,2'b00,2'b00,3'b000), "streq_mw");
        fd(tbl, 12'hE58, "str");
        v(tbl, 12'hE58, 4'hF, o(0,0,0,0,2'b01,2'b00,3'b000), "str_ma");
        v(tbl, 12'hE58, 4'hF, o(0,1,0,1,2'b00,2'b00,3'b000), "str_mw");
        // Undefined op: two cycles
        fd(tbl, 12'hEC0, "undef");
        // SUBS setting N,Z, confirm with BEQ, then LDR up to MEMADR
        fd(tbl, 12'hE25, "subs2");
        v(tbl, 12'hE25, 4'hC, o(0,0,0,0,2'b01,2'b00,3'b001), "subs2_exi");
        v(tbl, 12'hE25, 4'hF, o(0,0,1,0,2'b00,2'b00,3'b000), "subs2_wb");
        fd(tbl, 12'h0A0, "beq4");
        v(tbl, 12'h0A0, 4'hF, o(1,0,0,0,2'b01,2'b10,3'b000), "beq4_br");
        fd(tbl, 12'hE51, "ldr2");
        v(tbl, 12'hE51, 4'hF, o(0,0,0,0,2'b01,2'b00,3'b001), "ldr2_ma");
        // After reset: flags cleared, so EQ and MI fail
        fd(tbl2, 12'h0A0, "rbeq");
        v(tbl2, 12'h0A0, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "rbeq_br");
        fd(tbl2, 12'h4A0, "rbmi");
        v(tbl2, 12'h4A0, 4'hF, o(0,0,0,0,2'b01,2'b10,3'b000), "rbmi_br");

        reset    = 1'b1;
        Instr    = 12'h000;
        ALUFlags = 4'h0;
        @(negedge clk);
        chk("reset_held", act(), {4'b0000, OF});
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(tbl);

        // Now in MEMREAD of ldr2; abort it with reset mid-cycle.
        chk("ldr2_mr", act(), {rsi(12'hE51), o(0,0,0,1,2'b00,2'b00,3'b000)});
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async", act(), {rsi(12'hE51), OF});
        @(negedge clk);
        chk("reset_hold2", act(), {rsi(12'hE51), OF});
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("after_rel", act(), {rsi(12'hE51), OF});

        run(tbl2);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
